// File: rtl/wisard_serial_classifier_pkg.sv
// Shared types and width helpers for the serial WiSARD classifier.
package wisard_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    ACCUM,
    WAIT,
    ARGMAX,
    DONE
  } state_t;

  localparam int N_CLASSES_DEF = 2;

  typedef logic [N_CLASSES_DEF-1:0] hit_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int class_width(input int n_classes);
    return clog2_min1(n_classes);
  endfunction

  function automatic int cnt_width(input int num_pos);
    return clog2_min1(num_pos + 1);
  endfunction

endpackage

// File: rtl/wisard_serial_classifier_if.sv
// Tuple stream, LUT bus and prediction signals between the tester and the classifier.
interface wisard_serial_classifier_if #(
  parameter int N_CLASSES   = 2,
  parameter int TUPLE_WIDTH = 8,
  parameter int POS_WIDTH   = 6,
  parameter int CLASS_WIDTH = 1
);
  logic                   tuple_bit;
  logic                   tuple_valid;
  logic                   sop;
  logic [TUPLE_WIDTH-1:0] tuple_addr;
  logic [POS_WIDTH-1:0]   tuple_pos;
  logic                   addr_valid;
  logic [N_CLASSES-1:0]   lut_out_t;
  logic                   cnt_mux_sel;
  logic [N_CLASSES-1:0]   cnt_mux_ext;
  logic                   prediction_valid;
  logic [CLASS_WIDTH-1:0] predicted_class;
  logic                   busy;
  logic                   overrun;

  modport master (
    output tuple_bit, tuple_valid, sop, lut_out_t, cnt_mux_sel, cnt_mux_ext,
    input  tuple_addr, tuple_pos, addr_valid, prediction_valid, predicted_class, busy, overrun
  );

  modport slave (
    input  tuple_bit, tuple_valid, sop, lut_out_t, cnt_mux_sel, cnt_mux_ext,
    output tuple_addr, tuple_pos, addr_valid, prediction_valid, predicted_class, busy, overrun
  );

endinterface

// File: rtl/wisard_serial_classifier_argmax_seq.sv
// Sequential argmax over a packed vote vector, one class per cycle, ties to the lowest index.
module wisard_argmax_seq #(
  parameter int N_CLASSES   = 2,
  parameter int CLASS_WIDTH = 1,
  parameter int CNT_WIDTH   = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_i,
  input  logic [N_CLASSES*CNT_WIDTH-1:0] votes_i,
  output logic                           done_o,
  output logic [CLASS_WIDTH-1:0]         idx_o
);

  logic                   run_q;
  logic [CLASS_WIDTH-1:0] i_q;
  logic [CLASS_WIDTH-1:0] idx_q;
  logic [CNT_WIDTH-1:0]   best_q;
  logic [CLASS_WIDTH-1:0] cur_i;
  logic [CLASS_WIDTH-1:0] idx_d;
  logic [CNT_WIDTH-1:0]   best_d;
  logic [CNT_WIDTH-1:0]   cur;

  // The start cycle evaluates class 0, so done/idx of the last class are available combinationally.
  always_comb begin
    cur_i  = start_i ? '0 : i_q;
    cur    = votes_i[int'(cur_i)*CNT_WIDTH +: CNT_WIDTH];
    best_d = best_q;
    idx_d  = idx_q;
    if (start_i || (cur > best_q)) begin
      best_d = cur;
      idx_d  = cur_i;
    end
    done_o = (start_i || run_q) && (cur_i == CLASS_WIDTH'(N_CLASSES - 1));
  end

  assign idx_o = idx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q  <= 1'b0;
      i_q    <= '0;
      idx_q  <= '0;
      best_q <= '0;
    end else if (start_i || run_q) begin
      best_q <= best_d;
      idx_q  <= idx_d;
      i_q    <= cur_i + 1'b1;
      run_q  <= !done_o;
    end
  end

endmodule

// File: rtl/wisard_serial_classifier.sv
// Serial tuple receiver: deserialises tuples, accumulates per-class LUT hits, reports the argmax class.
module wisard_serial_classifier
  import wisard_pkg::*;
#(
  parameter int N_CLASSES    = 2,
  parameter int CLASS_WIDTH  = class_width(N_CLASSES),
  parameter int TUPLE_WIDTH  = 8,
  parameter int BITCNT_WIDTH = clog2_min1(TUPLE_WIDTH),
  parameter int NUM_POS      = 47,
  parameter int POS_WIDTH    = clog2_min1(NUM_POS),
  parameter int CNT_WIDTH    = cnt_width(NUM_POS)
) (
  input logic                       clk,
  input logic                       rst,
  wisard_serial_classifier_if.slave bus
);

  state_t                         state_q;
  logic [TUPLE_WIDTH-1:0]         shreg_q;
  logic [TUPLE_WIDTH-1:0]         addr_d;
  logic [BITCNT_WIDTH-1:0]        bitcnt_q;
  logic [POS_WIDTH-1:0]           pos_q;
  logic [CNT_WIDTH-1:0]           cnt_q [N_CLASSES];
  logic [N_CLASSES-1:0]           hit_d;
  logic [N_CLASSES*CNT_WIDTH-1:0] votes;

  logic [TUPLE_WIDTH-1:0]         tuple_addr_q;
  logic [POS_WIDTH-1:0]           tuple_pos_q;
  logic                           addr_valid_q;
  logic                           pred_valid_q;
  logic [CLASS_WIDTH-1:0]         pred_class_q;
  logic                           busy_q;
  logic                           overrun_q;
  logic                           arg_start_q;

  logic                           arg_done;
  logic [CLASS_WIDTH-1:0]         arg_idx;
  logic                           restart;
  logic                           late_tuple;

  always_comb begin
    addr_d           = shreg_q;
    addr_d[bitcnt_q] = bus.tuple_bit;
  end

  always_comb hit_d = bus.cnt_mux_sel ? bus.cnt_mux_ext : bus.lut_out_t;

  always_comb begin
    votes = '0;
    for (int unsigned c = 0; c < N_CLASSES; c++) begin
      votes[c*CNT_WIDTH +: CNT_WIDTH] = cnt_q[c];
    end
  end

  assign restart    = bus.tuple_valid && bus.sop && ((state_q == IDLE) || (state_q == WAIT));
  assign late_tuple = bus.tuple_valid && ((state_q == ARGMAX) || (state_q == DONE));

  wisard_argmax_seq #(
    .N_CLASSES  (N_CLASSES),
    .CLASS_WIDTH(CLASS_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_argmax (
    .clk    (clk),
    .rst    (rst),
    .start_i(arg_start_q),
    .votes_i(votes),
    .done_o (arg_done),
    .idx_o  (arg_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      pos_q        <= '0;
      for (int unsigned c = 0; c < N_CLASSES; c++) cnt_q[c] <= '0;
      tuple_addr_q <= '0;
      tuple_pos_q  <= '0;
      addr_valid_q <= 1'b0;
      pred_valid_q <= 1'b0;
      pred_class_q <= '0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      arg_start_q  <= 1'b0;
    end else begin
      addr_valid_q <= 1'b0;
      pred_valid_q <= 1'b0;
      arg_start_q  <= 1'b0;
      if (late_tuple) overrun_q <= 1'b1;
      // sop in IDLE and WAIT share one restart path; only the WAIT case is an overrun.
      if (restart) begin
        for (int unsigned c = 0; c < N_CLASSES; c++) cnt_q[c] <= '0;
        pos_q    <= '0;
        shreg_q  <= addr_d;
        bitcnt_q <= BITCNT_WIDTH'(1);
        busy_q   <= 1'b1;
        state_q  <= SHIFT;
        if (state_q == WAIT) overrun_q <= 1'b1;
      end else begin
        case (state_q)
          SHIFT: begin
            shreg_q <= addr_d;
            if (bitcnt_q == BITCNT_WIDTH'(TUPLE_WIDTH - 1)) begin
              bitcnt_q     <= '0;
              tuple_addr_q <= addr_d;
              tuple_pos_q  <= pos_q;
              addr_valid_q <= 1'b1;
              state_q      <= ACCUM;
            end else begin
              bitcnt_q <= bitcnt_q + 1'b1;
            end
          end
          ACCUM: begin
            for (int unsigned c = 0; c < N_CLASSES; c++) begin
              cnt_q[c] <= cnt_q[c] + CNT_WIDTH'(hit_d[c]);
            end
            if (pos_q == POS_WIDTH'(NUM_POS - 1)) begin
              arg_start_q <= 1'b1;
              state_q     <= ARGMAX;
            end else begin
              pos_q   <= pos_q + 1'b1;
              state_q <= WAIT;
            end
          end
          WAIT: begin
            if (bus.tuple_valid) begin
              shreg_q  <= addr_d;
              bitcnt_q <= BITCNT_WIDTH'(1);
              state_q  <= SHIFT;
            end
          end
          ARGMAX: begin
            if (arg_done) begin
              pred_valid_q <= 1'b1;
              pred_class_q <= arg_idx;
              busy_q       <= 1'b0;
              state_q      <= DONE;
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.tuple_addr       = tuple_addr_q;
  assign bus.tuple_pos        = tuple_pos_q;
  assign bus.addr_valid       = addr_valid_q;
  assign bus.prediction_valid = pred_valid_q;
  assign bus.predicted_class  = pred_class_q;
  assign bus.busy             = busy_q;
  assign bus.overrun          = overrun_q;

endmodule

// File: tb/tb_wisard_serial_classifier.sv
// Bench for wisard_serial_classifier with N_CLASSES=2, NUM_POS=3, TUPLE_WIDTH=8.
module tb_wisard_serial_classifier;
  import wisard_pkg::*;

  localparam int NC  = 2;
  localparam int NP  = 3;
  localparam int TW  = 8;
  localparam int PW  = 2;
  localparam int CW  = 1;
  localparam int GAP = 8;
  localparam int LAT = NC + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wisard_serial_classifier_if #(
    .N_CLASSES  (NC),
    .TUPLE_WIDTH(TW),
    .POS_WIDTH  (PW),
    .CLASS_WIDTH(CW)
  ) bus ();

  wisard_serial_classifier #(
    .N_CLASSES  (NC),
    .TUPLE_WIDTH(TW),
    .NUM_POS    (NP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  hit_t lut_tab [0:3];
  always_comb bus.lut_out_t = lut_tab[bus.tuple_pos];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [TW-1:0] addr;
    logic [PW-1:0] pos;
    int unsigned   c;
  } av_t;
  typedef struct {
    logic [CW-1:0] cls;
    int unsigned   c;
  } pv_t;
  av_t av_q[$];
  pv_t pv_q[$];

  always @(negedge clk) begin
    if (bus.addr_valid === 1'b1) av_q.push_back('{addr: bus.tuple_addr, pos: bus.tuple_pos, c: cyc});
    if (bus.prediction_valid === 1'b1) pv_q.push_back('{cls: bus.predicted_class, c: cyc});
  end

  int total = 0;
  int bad   = 0;
  logic [TW-1:0] tup [NP];
  hit_t          hit [NP];
  int unsigned   last_k;

  // Reference: votes per class are the number of tuples hitting it; first maximum wins.
  function automatic int ref_count(input int c);
    int n = 0;
    for (int t = 0; t < NP; t++) if (hit[t][c]) n++;
    return n;
  endfunction

  function automatic int ref_class();
    int best = -1;
    int cls  = 0;
    for (int c = 0; c < NC; c++) begin
      if (ref_count(c) > best) begin
        best = ref_count(c);
        cls  = c;
      end
    end
    return cls;
  endfunction

  task automatic send_tuple(input logic [TW-1:0] d, input logic s);
    @(posedge clk); #1;
    bus.tuple_valid = 1'b1;
    bus.sop         = s;
    bus.tuple_bit   = d[0];
    for (int i = 1; i < TW; i++) begin
      @(posedge clk); #1;
      bus.tuple_valid = 1'b0;
      bus.sop         = 1'b0;
      bus.tuple_bit   = d[i];
    end
    last_k = cyc;
    @(posedge clk); #1;
    bus.tuple_bit = 1'b0;
  endtask

  task automatic run_sample(input bit ovr, input hit_t lut_val, input bit stray);
    for (int p = 0; p < NP; p++) lut_tab[p] = ovr ? lut_val : hit[p];
    for (int t = 0; t < NP; t++) begin
      send_tuple(tup[t], t == 0);
      if (t < NP - 1) repeat (GAP) @(posedge clk);
    end
    if (stray) begin
      @(posedge clk); #1;
      bus.tuple_valid = 1'b1;
      bus.tuple_bit   = 1'b1;
      @(posedge clk); #1;
      bus.tuple_valid = 1'b0;
      bus.tuple_bit   = 1'b0;
    end
    repeat (12) @(posedge clk);
  endtask

  task automatic randomize_sample();
    for (int t = 0; t < NP; t++) begin
      tup[t] = TW'($urandom);
      hit[t] = hit_t'($urandom_range(0, 3));
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.tuple_bit = 1'b0; bus.tuple_valid = 1'b0; bus.sop = 1'b0;
    bus.cnt_mux_sel = 1'b0; bus.cnt_mux_ext = '0;
    for (int p = 0; p < 4; p++) lut_tab[p] = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    total++; if (bus.addr_valid !== 1'b0) begin bad++; $display("FAIL reset_addr_valid: got %0b want 0", bus.addr_valid); end
    total++; if (bus.tuple_addr !== '0) begin bad++; $display("FAIL reset_tuple_addr: got %0h want 0", bus.tuple_addr); end
    total++; if (bus.tuple_pos !== '0) begin bad++; $display("FAIL reset_tuple_pos: got %0d want 0", bus.tuple_pos); end
    total++; if (bus.prediction_valid !== 1'b0) begin bad++; $display("FAIL reset_pred_valid: got %0b want 0", bus.prediction_valid); end
    total++; if (bus.predicted_class !== '0) begin bad++; $display("FAIL reset_pred_class: got %0d want 0", bus.predicted_class); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %0b want 0", bus.overrun); end
    rst = 1'b0;
    av_q.delete(); pv_q.delete();
    send_tuple(8'hFF, 1'b0);
    repeat (12) @(posedge clk);
    total++; if (av_q.size() != 0) begin bad++; $display("FAIL idle_no_sop_ignored: got %0d addr strobes want 0", av_q.size()); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_no_sop_busy: got %0b want 0", bus.busy); end
  endtask

  task automatic test_single();
    tup = '{8'hA5, 8'h3C, 8'hFF};
    hit = '{2'b01, 2'b10, 2'b10};
    av_q.delete(); pv_q.delete();
    run_sample(1'b0, '0, 1'b0);
    total++; if (av_q.size() != NP) begin bad++; $display("FAIL single_addr_count: got %0d want %0d", av_q.size(), NP); end
    for (int p = 0; p < NP && p < av_q.size(); p++) begin
      total++; if (av_q[p].addr !== tup[p]) begin bad++; $display("FAIL single_addr[%0d]: got %0h want %0h", p, av_q[p].addr, tup[p]); end
      total++; if (av_q[p].pos !== PW'(p)) begin bad++; $display("FAIL single_pos[%0d]: got %0d want %0d", p, av_q[p].pos, p); end
    end
    if (av_q.size() == NP) begin
      total++; if (av_q[NP-1].c != last_k + 1) begin bad++; $display("FAIL single_addr_latency: got cycle %0d want %0d", av_q[NP-1].c, last_k + 1); end
    end
    total++; if (pv_q.size() != 1) begin bad++; $display("FAIL single_pred_pulses: got %0d want 1", pv_q.size()); end
    if (pv_q.size() > 0) begin
      total++; if (pv_q[0].cls !== CW'(ref_class())) begin bad++; $display("FAIL single_class: got %0d want %0d", pv_q[0].cls, ref_class()); end
      total++; if (pv_q[0].c != last_k + LAT) begin bad++; $display("FAIL single_pred_latency: got cycle %0d want %0d", pv_q[0].c, last_k + LAT); end
    end
    for (int c = 0; c < NC; c++) begin
      total++; if (int'(dut.cnt_q[c]) != ref_count(c)) begin bad++; $display("FAIL single_count[%0d]: got %0d want %0d", c, dut.cnt_q[c], ref_count(c)); end
    end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_busy_after: got %0b want 0", bus.busy); end
  endtask

  task automatic test_tie();
    randomize_sample();
    hit = '{2'b11, 2'b11, 2'b00};
    pv_q.delete();
    run_sample(1'b0, '0, 1'b0);
    total++; if (pv_q.size() != 1) begin bad++; $display("FAIL tie_pred_pulses: got %0d want 1", pv_q.size()); end
    if (pv_q.size() > 0) begin
      total++; if (pv_q[0].cls !== CW'(ref_class())) begin bad++; $display("FAIL tie_class: got %0d want %0d", pv_q[0].cls, ref_class()); end
    end
    for (int c = 0; c < NC; c++) begin
      total++; if (int'(dut.cnt_q[c]) != ref_count(c)) begin bad++; $display("FAIL tie_count[%0d]: got %0d want %0d", c, dut.cnt_q[c], ref_count(c)); end
    end
  endtask

  task automatic test_seq_mode();
    randomize_sample();
    for (int t = 0; t < NP; t++) hit[t] = 2'b10;
    bus.cnt_mux_sel = 1'b1;
    bus.cnt_mux_ext = 2'b10;
    pv_q.delete();
    run_sample(1'b1, 2'b01, 1'b0);
    total++; if (pv_q.size() != 1) begin bad++; $display("FAIL seq_pred_pulses: got %0d want 1", pv_q.size()); end
    if (pv_q.size() > 0) begin
      total++; if (pv_q[0].cls !== CW'(ref_class())) begin bad++; $display("FAIL seq_class: got %0d want %0d", pv_q[0].cls, ref_class()); end
    end
    for (int c = 0; c < NC; c++) begin
      total++; if (int'(dut.cnt_q[c]) != ref_count(c)) begin bad++; $display("FAIL seq_count[%0d]: got %0d want %0d", c, dut.cnt_q[c], ref_count(c)); end
    end
    bus.cnt_mux_sel = 1'b0;
    bus.cnt_mux_ext = '0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      randomize_sample();
      av_q.delete(); pv_q.delete();
      run_sample(1'b0, '0, 1'b0);
      total++; if (pv_q.size() != 1) begin bad++; $display("FAIL rand%0d_pred_pulses: got %0d want 1", n, pv_q.size()); end
      if (pv_q.size() > 0) begin
        total++; if (pv_q[0].cls !== CW'(ref_class())) begin bad++; $display("FAIL rand%0d_class: got %0d want %0d", n, pv_q[0].cls, ref_class()); end
      end
      for (int p = 0; p < NP && p < av_q.size(); p++) begin
        total++; if (av_q[p].addr !== tup[p]) begin bad++; $display("FAIL rand%0d_addr[%0d]: got %0h want %0h", n, p, av_q[p].addr, tup[p]); end
      end
    end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL rand_overrun_clear: got %0b want 0", bus.overrun); end
  endtask

  task automatic test_early_sop();
    randomize_sample();
    lut_tab[0] = 2'b10; lut_tab[1] = 2'b10;
    av_q.delete(); pv_q.delete();
    send_tuple(tup[0], 1'b1);
    repeat (GAP) @(posedge clk);
    send_tuple(tup[1], 1'b0);
    repeat (GAP) @(posedge clk);
    randomize_sample();
    hit = '{2'b01, 2'b01, 2'b10};
    run_sample(1'b0, '0, 1'b0);
    total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL early_sop_overrun: got %0b want 1", bus.overrun); end
    total++; if (pv_q.size() != 1) begin bad++; $display("FAIL early_sop_pred_pulses: got %0d want 1", pv_q.size()); end
    if (pv_q.size() > 0) begin
      total++; if (pv_q[0].cls !== CW'(ref_class())) begin bad++; $display("FAIL early_sop_class: got %0d want %0d", pv_q[0].cls, ref_class()); end
    end
    for (int c = 0; c < NC; c++) begin
      total++; if (int'(dut.cnt_q[c]) != ref_count(c)) begin bad++; $display("FAIL early_sop_count[%0d]: got %0d want %0d", c, dut.cnt_q[c], ref_count(c)); end
    end
    if (av_q.size() > 2) begin
      total++; if (av_q[2].pos !== '0) begin bad++; $display("FAIL early_sop_pos_restart: got %0d want 0", av_q[2].pos); end
    end
    repeat (GAP) @(posedge clk);
    total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL early_sop_overrun_sticky: got %0b want 1", bus.overrun); end
    pulse_reset();
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL overrun_cleared_by_reset: got %0b want 0", bus.overrun); end
  endtask

  task automatic test_overrun_argmax();
    randomize_sample();
    av_q.delete(); pv_q.delete();
    run_sample(1'b0, '0, 1'b1);
    total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL argmax_overrun: got %0b want 1", bus.overrun); end
    total++; if (av_q.size() != NP) begin bad++; $display("FAIL argmax_dropped_tuple: got %0d addr strobes want %0d", av_q.size(), NP); end
    total++; if (pv_q.size() != 1) begin bad++; $display("FAIL argmax_pred_pulses: got %0d want 1", pv_q.size()); end
    if (pv_q.size() > 0) begin
      total++; if (pv_q[0].cls !== CW'(ref_class())) begin bad++; $display("FAIL argmax_class: got %0d want %0d", pv_q[0].cls, ref_class()); end
      total++; if (pv_q[0].c != last_k + LAT) begin bad++; $display("FAIL argmax_pred_latency: got cycle %0d want %0d", pv_q[0].c, last_k + LAT); end
    end
    pulse_reset();
  endtask

  task automatic test_reset_mid();
    int exp_cls [2];
    randomize_sample();
    for (int p = 0; p < NP; p++) lut_tab[p] = hit[p];
    send_tuple(tup[0], 1'b1);
    repeat (GAP) @(posedge clk);
    @(posedge clk); #1; bus.tuple_valid = 1'b1; bus.tuple_bit = tup[1][0];
    @(posedge clk); #1; bus.tuple_valid = 1'b0; bus.tuple_bit = tup[1][1];
    @(posedge clk); #1; bus.tuple_bit = tup[1][2];
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %0b want 1", bus.busy); end
    av_q.delete(); pv_q.delete();
    rst = 1'b1;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_reset_busy: got %0b want 0", bus.busy); end
    total++; if (bus.tuple_addr !== '0) begin bad++; $display("FAIL mid_reset_tuple_addr: got %0h want 0", bus.tuple_addr); end
    total++; if (bus.tuple_pos !== '0) begin bad++; $display("FAIL mid_reset_tuple_pos: got %0d want 0", bus.tuple_pos); end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.tuple_bit = 1'b0;
    for (int s = 0; s < 2; s++) begin
      randomize_sample();
      exp_cls[s] = ref_class();
      run_sample(1'b0, '0, 1'b0);
    end
    total++; if (pv_q.size() != 2) begin bad++; $display("FAIL mid_pred_pulses: got %0d want 2", pv_q.size()); end
    for (int s = 0; s < 2 && s < pv_q.size(); s++) begin
      total++; if (pv_q[s].cls !== CW'(exp_cls[s])) begin bad++; $display("FAIL mid_class[%0d]: got %0d want %0d", s, pv_q[s].cls, exp_cls[s]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_seq_mode();
    test_random();
    test_early_sop();
    test_overrun_argmax();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
